// File: rtl/mem_stage_sb_if.sv
// mem_stage_sb_if: MEM-stage request/response bundle between the pipeline and mem_stage_sb.
interface mem_stage_sb_if #(parameter int SB_PTR_BITS = 2);
  logic [31:0] alu_result;
  logic [31:0] rd2_orig;
  logic [31:0] wb_back;
  logic rd2_forward;
  logic mem_write;
  logic mem_read;
  logic [2:0] dm_ctrl;
  logic [31:0] pc;
  logic [31:0] mem_rd;
  logic stall;
  logic [SB_PTR_BITS:0] sb_count;
  modport master (
    output alu_result, rd2_orig, wb_back, rd2_forward, mem_write, mem_read, dm_ctrl, pc,
    input mem_rd, stall, sb_count
  );
  modport slave (
    input alu_result, rd2_orig, wb_back, rd2_forward, mem_write, mem_read, dm_ctrl, pc,
    output mem_rd, stall, sb_count
  );
endinterface

// File: rtl/mem_stage_sb.sv
// mem_stage_sb: MEM stage with in-order store buffer draining into a word-wide data memory.
// Define MEM_TRACE_EN to record each store's pc and print every drain write.
module mem_stage_sb #(
  parameter int ADDR_BITS = 12,
  parameter int SB_DEPTH = 4,
  parameter int SB_PTR_BITS = 2
) (
  input logic clk,
  input logic reset,
  mem_stage_sb_if.slave bus
);
  logic [31:0] mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] sb_idx [SB_DEPTH];
  logic [31:0] sb_data [SB_DEPTH];
  logic [3:0] sb_mask [SB_DEPTH];
  logic [SB_PTR_BITS-1:0] head, tail;
  logic [SB_PTR_BITS:0] count;
  logic [ADDR_BITS-1:0] idx;
  logic [1:0] lane;
  logic [31:0] sd, st_data, ld_word, ext, merged;
  logic [3:0] st_mask;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  logic is_byte, is_half, full, hit, stall, enq, drain;
  assign idx = bus.alu_result[ADDR_BITS+1:2];
  assign lane = bus.alu_result[1:0];
  assign sd = bus.rd2_forward ? bus.wb_back : bus.rd2_orig;
  assign is_half = bus.dm_ctrl == 3'd1 || bus.dm_ctrl == 3'd2;
  assign is_byte = bus.dm_ctrl == 3'd3 || bus.dm_ctrl == 3'd4;
  assign st_data = is_byte ? {4{sd[7:0]}} : is_half ? {2{sd[15:0]}} : sd;
  assign st_mask = is_byte ? 4'b0001 << lane : is_half ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign full = count == (SB_PTR_BITS+1)'(SB_DEPTH);
  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++)
      if ({1'b0, SB_PTR_BITS'(SB_PTR_BITS'(i) - head)} < count && sb_idx[i] == idx) hit = 1'b1;
  end
  assign stall = (bus.mem_write & full) | (bus.mem_read & ~bus.mem_write & hit);
  assign enq = bus.mem_write & ~stall;
  assign drain = count != '0 && (~bus.mem_read || stall);
  assign ld_word = mem[idx];
  assign lane_b = ld_word[{lane, 3'b000} +: 8];
  assign lane_h = lane[1] ? ld_word[31:16] : ld_word[15:0];
  assign ext = bus.dm_ctrl == 3'd1 ? {16'b0, lane_h} :
               bus.dm_ctrl == 3'd2 ? {{16{lane_h[15]}}, lane_h} :
               bus.dm_ctrl == 3'd3 ? {24'b0, lane_b} :
               bus.dm_ctrl == 3'd4 ? {{24{lane_b[7]}}, lane_b} : ld_word;
  always_comb begin
    merged = mem[sb_idx[head]];
    for (int b = 0; b < 4; b++)
      if (sb_mask[head][b]) merged[8*b +: 8] = sb_data[head][8*b +: 8];
  end
  assign bus.mem_rd = (bus.mem_read & ~bus.mem_write & ~stall) ? ext : 32'b0;
  assign bus.stall = stall;
  assign bus.sb_count = count;
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2**ADDR_BITS; i++) mem[i] <= '0;
    end else if (drain) begin
      mem[sb_idx[head]] <= merged;
    end
  end
`ifdef MEM_TRACE_EN
  logic [31:0] sb_pc [SB_DEPTH];
  always_ff @(posedge clk) begin
    if (reset && enq) sb_pc[tail] <= bus.pc;
    if (reset && drain)
      $display("@%08h: *%08h <= %08h", sb_pc[head], {{(30-ADDR_BITS){1'b0}}, sb_idx[head], 2'b00}, merged);
  end
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.alu_result[31:ADDR_BITS+2]};
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.pc, bus.alu_result[31:ADDR_BITS+2]};
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        sb_idx[tail] <= idx;
        sb_data[tail] <= st_data;
        sb_mask[tail] <= st_mask;
        tail <= tail + 1'b1;
      end
      if (drain) head <= head + 1'b1;
      count <= count + (SB_PTR_BITS+1)'(enq) - (SB_PTR_BITS+1)'(drain);
    end
  end
endmodule

// File: tb/tb_mem_stage_sb.sv
// tb_mem_stage_sb: directed checks of store buffering, forwarding, hazards and load extension.
module tb_mem_stage_sb;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int fails = 0;
  mem_stage_sb_if #(.SB_PTR_BITS(2)) bus ();
  mem_stage_sb #(.ADDR_BITS(12), .SB_DEPTH(4), .SB_PTR_BITS(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    bus.mem_write = w;
    bus.mem_read = r;
    bus.alu_result = a;
    bus.rd2_orig = d;
    bus.dm_ctrl = c;
    bus.rd2_forward = 1'b0;
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b0;
    bus.wb_back = '0;
    bus.pc = '0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    check("reset_stall", {31'b0, bus.stall}, 0);
    check("reset_count", {29'b0, bus.sb_count}, 0);
    check("reset_rd", bus.mem_rd, 0);
    reset = 1'b1;
    drive(1, 0, 32'h10, 32'h12345678, 0);
    check("sw_stall", {31'b0, bus.stall}, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("sw_count1", {29'b0, bus.sb_count}, 1);
    tick();
    check("sw_drained", {29'b0, bus.sb_count}, 0);
    tick();
    drive(0, 1, 32'h10, 0, 0);
    check("lw_10", bus.mem_rd, 32'h12345678);
    check("lw_10_stall", {31'b0, bus.stall}, 0);
    drive(0, 1, 32'h4010, 0, 0);
    check("lw_wrap", bus.mem_rd, 32'h12345678);
    drive(0, 1, 32'h13, 0, 3'd5);
    check("lw_ctrl5", bus.mem_rd, 32'h12345678);
    drive(0, 1, 32'h12, 0, 3'd1);
    check("lhu_12", bus.mem_rd, 32'h00001234);
    tick();
    drive(1, 0, 32'h21, 32'h80, 3'd3);
    tick();
    drive(0, 1, 32'h21, 0, 3'd4);
    check("lb_conflict_stall", {31'b0, bus.stall}, 1);
    check("lb_conflict_rd", bus.mem_rd, 0);
    tick();
    check("lb_after_stall", {31'b0, bus.stall}, 0);
    check("lb_21", bus.mem_rd, 32'hFFFFFF80);
    drive(0, 1, 32'h21, 0, 3'd3);
    check("lbu_21", bus.mem_rd, 32'h00000080);
    drive(0, 1, 32'h20, 0, 3'd0);
    check("lw_20", bus.mem_rd, 32'h00008000);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'h100 + 4 * i, 32'hA0000001 + i, 0);
      check("wr_rd_rd", bus.mem_rd, 0);
      tick();
    end
    check("full_count", {29'b0, bus.sb_count}, 4);
    drive(1, 1, 32'h110, 32'hA0000005, 0);
    check("full_stall", {31'b0, bus.stall}, 1);
    tick();
    check("full_drained", {29'b0, bus.sb_count}, 3);
    check("full_stall_gone", {31'b0, bus.stall}, 0);
    tick();
    check("full_refilled", {29'b0, bus.sb_count}, 4);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    check("full_empty", {29'b0, bus.sb_count}, 0);
    drive(0, 1, 32'h100, 0, 0);
    check("lw_100", bus.mem_rd, 32'hA0000001);
    drive(0, 1, 32'h10C, 0, 0);
    check("lw_10c", bus.mem_rd, 32'hA0000004);
    drive(0, 1, 32'h110, 0, 0);
    check("lw_110", bus.mem_rd, 32'hA0000005);
    tick();
    drive(1, 0, 32'h2, 32'h0, 3'd1);
    bus.rd2_forward = 1'b1;
    bus.wb_back = 32'hAAAA8001;
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 32'h0, 0, 0);
    check("sh_fwd_word", bus.mem_rd, 32'h80010000);
    drive(0, 1, 32'h2, 0, 3'd2);
    check("lh_2", bus.mem_rd, 32'hFFFF8001);
    drive(0, 1, 32'h2, 0, 3'd1);
    check("lhu_2", bus.mem_rd, 32'h00008001);
    drive(0, 1, 32'h0, 0, 3'd2);
    check("lh_0", bus.mem_rd, 32'h00000000);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h200 + 4 * i, 32'h5A5A0000 + i, 0);
      tick();
    end
    check("pre_reset_count", {29'b0, bus.sb_count}, 3);
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("post_reset_count", {29'b0, bus.sb_count}, 0);
    drive(0, 1, 32'h200, 0, 0);
    check("post_reset_200", bus.mem_rd, 0);
    drive(0, 1, 32'h208, 0, 0);
    check("post_reset_208", bus.mem_rd, 0);
    drive(0, 1, 32'h10, 0, 0);
    check("post_reset_10", bus.mem_rd, 0);
    tick();
    bus.pc = 32'h00003004;
    drive(1, 0, 32'h8, 32'hDEADBEEF, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 32'h8, 0, 0);
    check("lw_8", bus.mem_rd, 32'hDEADBEEF);
    tick();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
